alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational ALU datapath between two requesters.
//   Round-robin arbitration and valid/ready request handshake.
//   Registers the operands, waits a fixed settle time, captures the ALU
//   result, and returns it on one response bus tagged with the requester id.
//   Sits between the bit-level ALU (AND/OR/NAND/EXOR/NOT) and its users.
// PARAMETERS
//   WIDTH   8   operand/result width in bits
//   OP_W    3   opcode width; opcode passed to ALU undecoded
//   SETTLE  2   cycles operands are held on ALU before result capture; >=1
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   req0_valid  in   1      requester 0 has an operation pending
//   req0_ready  out  1      requester 0 operation accepted this cycle
//   req0_op     in   OP_W   requester 0 opcode
//   req0_a      in   WIDTH  requester 0 operand a
//   req0_b      in   WIDTH  requester 0 operand b
//   req1_*      (same five signals for requester 1)
//   alu_op      out  OP_W   opcode driven to ALU
//   alu_a       out  WIDTH  operand a driven to ALU
//   alu_b       out  WIDTH  operand b driven to ALU
//   alu_y       in   WIDTH  ALU result, combinational from alu_*
//   rsp_valid   out  1      result available
//   rsp_id      out  1      requester that owns rsp_data
//   rsp_data    out  WIDTH  captured ALU result
//   rsp_ready   in   1      consumer accepts response
//   busy        out  1      high whenever state != IDLE
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE. rr_ptr=0 (req0 preferred).
//     All outputs 0. Any in-flight operation is discarded.
//   - FSM IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE grant: only one valid -> grant it. Both valid -> grant rr_ptr.
//     reqN_ready = (state==IDLE) & grantN, combinational, 1 cycle wide.
//     At most one ready is high per cycle.
//   - On grant: latch op/a/b into alu_* regs. rsp_id <= grant.
//     rr_ptr <= ~grant. cnt <= SETTLE-1. Go to EXEC.
//   - EXEC: alu_* are stable. cnt decrements each cycle. When cnt==0:
//     rsp_data <= alu_y, go to RESP.
//   - RESP: rsp_valid=1. rsp_id and rsp_data are held stable until
//     rsp_valid & rsp_ready, then go to IDLE. rsp_valid drops next cycle.
//   - No grant in the cycle a response is accepted.
//     Minimum period = SETTLE+2 cycles per transaction.
//   - Latency: handshake at cycle 0 -> rsp_valid first high at cycle
//     SETTLE+1.
//   - alu_* keep their last operands in IDLE/RESP (no toggling).
//   - valid dropped before grant: legal, nothing is latched.
//     Operands must be valid only in the handshake cycle.
//   - Fairness: a continuously valid requester is granted within 2 grants.
//     A lone requester is granted regardless of rr_ptr.
//   - rsp_ready is ignored outside RESP.
// STRUCTURE
//   - Package alu_pkg: opcode constants (OP_AND=0, OP_OR=1, OP_NAND=2,
//     OP_EXOR=3, OP_NOT=4), OP_W, FSM state encodings.
//   - Sub-module rr_arb2: 2-way round-robin arbiter.
//     Inputs: req[1:0], ptr, en. Outputs: gnt[1:0] one-hot, gnt_id.
//   - Top level holds the FSM, settle counter, operand regs, response regs.
// TESTING  (WIDTH=8, SETTLE=2, real ALU on alu_*)
//   1. req0 OP_AND a=F0 b=3C, rsp_ready=1 -> req0_ready at c0;
//      rsp_valid c3, rsp_id=0, rsp_data=30.
//   2. Both valid every cycle, rsp_ready=1 -> grants 0,1,0,1.
//      Period 4 cycles. rsp_id follows the same order.
//   3. req1 OP_EXOR a=AA b=FF, rsp_ready=0 for 5 cycles -> rsp_valid=1,
//      data=55 stable. No reqN_ready while held.
//   4. req1 alone three times -> granted each time, no bubble.
//      rr_ptr ends at 0.
//   5. rst=1 during EXEC -> all outputs 0 immediately, busy=0.
//      Next both-valid grant goes to req0.
//   6. req0 valid 1 cycle during RESP, then dropped -> never granted.
//      No req0_ready, no extra response.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the shared-ALU request arbiter.
// Opcodes pass through to the ALU undecoded; only the encodings live here.
package alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_EXOR = 3'd3,
      OP_NOT  = 3'd4
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational: a lone request always wins,
// a tie goes to ptr. gnt is one-hot and forced to zero when en is low.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      gnt_id = 1'b0;
      if (req == 2'b11) begin
         gnt_id = ptr;
      end else if (req[1]) begin
         gnt_id = 1'b1;
      end

      gnt = 2'b00;
      if (en && (req != 2'b00)) begin
         gnt = gnt_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; response appears SETTLE+1
// cycles after the request handshake and is held until rsp_ready, blocking new grants.
module alu_share_arbiter #(
   parameter int WIDTH  = 8,
   parameter int OP_W   = 3,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OP_W-1:0]  req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OP_W-1:0]  req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [OP_W-1:0]  alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   input  logic             rsp_ready,
   output logic             busy
);
   import alu_pkg::*;

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   if (SETTLE < 1) begin : g_bad_settle
      $error("alu_share_arbiter: SETTLE must be at least 1");
   end

   state_e           state;
   logic             rr_ptr;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       gnt;
   logic             gnt_id;
   logic             arb_en;

   // Gating with rst keeps the combinational readies low while reset is held.
   assign arb_en = (state == ST_IDLE) && !rst;

   rr_arb2 u_arb (
      .req    ({req1_valid, req0_valid}),
      .ptr    (rr_ptr),
      .en     (arb_en),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= 1'b0;
         cnt       <= '0;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt != 2'b00) begin
                  alu_op <= gnt_id ? req1_op : req0_op;
                  alu_a  <= gnt_id ? req1_a  : req0_a;
                  alu_b  <= gnt_id ? req1_b  : req0_b;
                  rsp_id <= gnt_id;
                  rr_ptr <= ~gnt_id;
                  cnt    <= CNT_W'(SETTLE - 1);
                  busy   <= 1'b1;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // Operands have been stable on the ALU for SETTLE cycles when cnt hits 0.
               if (cnt == '0) begin
                  rsp_data  <= alu_y;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
